// File: rtl/io_channel_unit_pkg.sv
//-----------------------------------------------------------------------------
// Module  : io_pkg
// Brief   : Channel numbers, status-word bit positions and the FIFO entry
//           type shared by the IO channel unit and its output FIFO.
// Rev     : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package io_pkg;

   // Channel map as seen through IO_read_sel / IO_write_sel
   localparam logic [2:0] CH_OUT0    = 3'd0;
   localparam logic [2:0] CH_OUT1    = 3'd1;
   localparam logic [2:0] CH_OUT2    = 3'd2;
   localparam logic [2:0] CH_OUT3    = 3'd3;
   localparam logic [2:0] CH_IN0     = 3'd4;
   localparam logic [2:0] CH_IN1     = 3'd5;
   localparam logic [2:0] CH_STATUS  = 3'd6;
   localparam logic [2:0] CH_SCRATCH = 3'd7;

   // Bit positions inside the status word (channel 6)
   localparam int STAT_OVF     = 14;
   localparam int STAT_CNT_MSB = 13;
   localparam int STAT_CNT_LSB = 11;

   // One queued output write: which channel and what was written
   typedef struct packed {
      logic [2:0]  sel;
      logic [14:0] data;
   } io_fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/io_channel_unit_out_fifo.sv
//-----------------------------------------------------------------------------
// Module  : io_out_fifo
// Brief   : Circular output FIFO of channel writes with a sticky overflow
//           flag. A push into a full FIFO is still accepted when the head is
//           popped in the same cycle; otherwise it is dropped and flagged.
// Rev     : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module io_out_fifo
   import io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4       // 2 or 4 entries
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           push,
   input  io_fifo_entry_t push_entry,
   input  logic           pop_req,
   input  logic           ovf_clear,
   output logic           push_ok,
   output logic           valid,
   output io_fifo_entry_t head,
   output logic [2:0]     count,
   output logic           overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   io_fifo_entry_t   mem [FIFO_DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic             full;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == 3'(FIFO_DEPTH));
   assign valid   = (count != 3'd0);
   assign pop     = pop_req && valid;
   assign push_ok = push && (!full || pop);
   assign head    = mem[head_ptr];

   // Entry storage; cleared on reset so the head reads zero when empty
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_ok) begin
         mem[tail_ptr] <= push_entry;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= 3'd0;
      end else begin
         if (push_ok) tail_ptr <= ptr_inc(tail_ptr);
         if (pop)     head_ptr <= ptr_inc(head_ptr);
         case ({push_ok, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: set by a dropped push, cleared only by software
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (push && !push_ok) begin
         overflow <= 1'b1;
      end else if (ovf_clear) begin
         overflow <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/io_channel_unit.sv
//-----------------------------------------------------------------------------
// Module  : io_channel_unit
// Brief   : Eight IO channels behind the Core's IO port. Channels 0-3 are
//           latched outputs also queued to a peripheral; channels 4-5 are
//           peripheral inputs with pending flags; channel 6 is status;
//           channel 7 is scratch.
//           Optional macro IO_INTR_EN adds the registered io_intr output.
// Rev     : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module io_channel_unit
   import io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        IO_write_en,
   input  logic [2:0]  IO_write_sel,
   input  logic [14:0] IO_write_data,
   input  logic [2:0]  IO_read_sel,
   output logic [14:0] IO_read_data,
   input  logic        IO_read_ack,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_sel,
   output logic [14:0] out_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sel,
   input  logic [14:0] in_data
`ifdef IO_INTR_EN
   ,
   output logic        io_intr
`endif
);

   logic [14:0]    ch_out [4];
   logic [14:0]    ch_in  [2];
   logic [14:0]    ch_scratch;
   logic [1:0]     pending;
   logic [14:0]    status;

   logic           wr_out;
   logic           ovf_clear;
   logic           accept;
   logic [1:0]     ack_clr;
   logic [1:0]     acc_set;

   io_fifo_entry_t push_entry;
   io_fifo_entry_t head;
   logic           push_ok;
   logic [2:0]     fifo_count;
   logic           overflow;

   assign wr_out     = IO_write_en && (IO_write_sel[2] == 1'b0);
   assign ovf_clear  = IO_write_en && (IO_write_sel == CH_STATUS) && IO_write_data[STAT_OVF];
   assign push_entry = '{sel: IO_write_sel, data: IO_write_data};

   assign in_ready   = ~pending[in_sel];
   assign accept     = in_valid && in_ready;
   assign acc_set    = accept ? (in_sel ? 2'b10 : 2'b01) : 2'b00;
   assign ack_clr[0] = IO_read_ack && (IO_read_sel == CH_IN0);
   assign ack_clr[1] = IO_read_ack && (IO_read_sel == CH_IN1);

   io_out_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (wr_out),
      .push_entry (push_entry),
      .pop_req    (out_ready),
      .ovf_clear  (ovf_clear),
      .push_ok    (push_ok),
      .valid      (out_valid),
      .head       (head),
      .count      (fifo_count),
      .overflow   (overflow)
   );

   assign out_sel  = head.sel;
   assign out_data = head.data;

   // Output and scratch channel registers; updated even if the FIFO drops
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            ch_out[i] <= '0;
         end
         ch_scratch <= '0;
      end else if (IO_write_en) begin
         if (wr_out) begin
            ch_out[IO_write_sel[1:0]] <= IO_write_data;
         end else if (IO_write_sel == CH_SCRATCH) begin
            ch_scratch <= IO_write_data;
         end
      end
   end

   // Input channels and pending flags; Core writes to 4/5 are ignored
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ch_in[0] <= '0;
         ch_in[1] <= '0;
         pending  <= 2'b00;
      end else begin
         if (accept) begin
            ch_in[in_sel] <= in_data;
         end
         pending <= (pending & ~ack_clr) | acc_set;
      end
   end

   // Status word rebuilt from live state every cycle
   always_comb begin
      status                            = '0;
      status[STAT_OVF]                  = overflow;
      status[STAT_CNT_MSB:STAT_CNT_LSB] = fifo_count;
      status[1:0]                       = pending;
   end

   // Combinational read port; writes become visible the following cycle
   always_comb begin
      IO_read_data = '0;
      case (IO_read_sel)
         CH_OUT0:    IO_read_data = ch_out[0];
         CH_OUT1:    IO_read_data = ch_out[1];
         CH_OUT2:    IO_read_data = ch_out[2];
         CH_OUT3:    IO_read_data = ch_out[3];
         CH_IN0:     IO_read_data = ch_in[0];
         CH_IN1:     IO_read_data = ch_in[1];
         CH_STATUS:  IO_read_data = status;
         CH_SCRATCH: IO_read_data = ch_scratch;
         default:    IO_read_data = '0;
      endcase
   end

`ifdef IO_INTR_EN
   // Interrupt follows any pending input with one cycle of delay
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         io_intr <= 1'b0;
      end else begin
         io_intr <= |pending;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_channel_unit.sv
//-----------------------------------------------------------------------------
// Module  : tb_io_channel_unit
// Brief   : Directed self-checking bench for io_channel_unit with a
//           scoreboard queue of expected output-link transfers.
//           Honours IO_INTR_EN when defined.
// Rev     : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_io_channel_unit;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        IO_write_en = 1'b0;
   logic [2:0]  IO_write_sel = '0;
   logic [14:0] IO_write_data = '0;
   logic [2:0]  IO_read_sel = '0;
   logic [14:0] IO_read_data;
   logic        IO_read_ack = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  out_sel;
   logic [14:0] out_data;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sel = 1'b0;
   logic [14:0] in_data = '0;
`ifdef IO_INTR_EN
   logic        io_intr;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [14:0] mch [8];
   logic [1:0]  mpend = 2'b00;
   logic        movf  = 1'b0;
   logic        mintr = 1'b0;
   logic [17:0] sb [$];

   io_channel_unit #(.FIFO_DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .IO_write_en   (IO_write_en),
      .IO_write_sel  (IO_write_sel),
      .IO_write_data (IO_write_data),
      .IO_read_sel   (IO_read_sel),
      .IO_read_data  (IO_read_data),
      .IO_read_ack   (IO_read_ack),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sel       (out_sel),
      .out_data      (out_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sel        (in_sel),
      .in_data       (in_data)
`ifdef IO_INTR_EN
      ,
      .io_intr       (io_intr)
`endif
   );

   always #20 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] model_status();
      logic [14:0] s;
      s        = '0;
      s[14]    = movf;
      s[13:11] = 3'(sb.size());
      s[1:0]   = mpend;
      return s;
   endfunction

   // Evaluate the model on the values held across the next rising edge
   task automatic step();
      logic        pop, full, push, acc, nintr;
      logic [17:0] ent;
      logic [1:0]  clr, set;
      @(negedge clock);
      full = (sb.size() == DEPTH);
      pop  = out_valid && out_ready;
      if (pop) begin
         chk("pop_has_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            ent = sb.pop_front();
            chk("pop_sel", 32'(out_sel), 32'(ent[17:15]));
            chk("pop_data", 32'(out_data), 32'(ent[14:0]));
         end
      end
      push = IO_write_en && (IO_write_sel < 3'd4);
      if (push) begin
         if (!full || pop) sb.push_back({IO_write_sel, IO_write_data});
         else movf = 1'b1;
      end
      if (IO_write_en) begin
         if (IO_write_sel < 3'd4 || IO_write_sel == 3'd7) mch[IO_write_sel] = IO_write_data;
         if (IO_write_sel == 3'd6 && IO_write_data[14]) movf = 1'b0;
      end
      nintr  = |mpend;
      clr[0] = IO_read_ack && (IO_read_sel == 3'd4);
      clr[1] = IO_read_ack && (IO_read_sel == 3'd5);
      acc    = in_valid && !mpend[in_sel];
      set    = acc ? (in_sel ? 2'b10 : 2'b01) : 2'b00;
      if (acc) mch[4 + int'(in_sel)] = in_data;
      mpend  = (mpend & ~clr) | set;
      mintr  = nintr;
      @(posedge clock);
      #1;
      IO_write_en = 1'b0;
      IO_read_ack = 1'b0;
      in_valid    = 1'b0;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [14:0] data);
      IO_write_en   = 1'b1;
      IO_write_sel  = sel;
      IO_write_data = data;
   endtask

   task automatic check_all(input string tag);
      logic [14:0] exp;
      for (int i = 0; i < 8; i++) begin
         IO_read_sel = 3'(i);
         #1;
         exp = (i == 6) ? model_status() : mch[i];
         chk($sformatf("%s_rd%0d", tag, i), 32'(IO_read_data), 32'(exp));
      end
      IO_read_sel = 3'd0;
      #1;
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk({tag, "_out_sel"}, 32'(out_sel), 32'(sb[0][17:15]));
         chk({tag, "_out_data"}, 32'(out_data), 32'(sb[0][14:0]));
      end
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(!mpend[in_sel]));
`ifdef IO_INTR_EN
      chk({tag, "_io_intr"}, 32'(io_intr), 32'(mintr));
`endif
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mch[i] = '0;

      // Reset and idle
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_sel", 32'(out_sel), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      reset_n = 1'b1;
      step();
      check_all("idle");

      // Single write to channel 2, then one-cycle drain
      wr(3'd2, 15'o12345);
      step();
      check_all("wr_ch2");
      chk("ch2_status", 32'(model_status()), 32'h0800);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_all("ch2_drained");

      // Overflow: five writes into a depth-4 FIFO
      for (int k = 1; k <= 5; k++) begin
         wr(3'd0, 15'(k));
         step();
      end
      check_all("ovf");
      IO_read_sel = 3'd6;
      #1;
      chk("ovf_status_lit", 32'(IO_read_data), 32'h6000);
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;
      check_all("ovf_drained");
      wr(3'd6, 15'o40000);
      step();
      IO_read_sel = 3'd6;
      #1;
      chk("ovf_cleared", 32'(IO_read_data), 32'd0);
      check_all("ovf_clr");

      // Full FIFO with simultaneous pop and push
      for (int k = 0; k < 4; k++) begin
         wr(3'd3, 15'(10 + k));
         step();
      end
      wr(3'd1, 15'o00777);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_all("full_pushpop");
      IO_read_sel = 3'd6;
      #1;
      chk("full_pushpop_status", 32'(IO_read_data), 32'h2000);
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;
      check_all("full_drained");

      // Scratch channel, no push
      wr(3'd7, 15'o70707);
      step();
      check_all("scratch");

      // Input link on channel 5
      in_valid = 1'b1; in_sel = 1'b1; in_data = 15'o00777;
      step();
      check_all("in_ch5");
      chk("in_ready_pend5", 32'(in_ready), 32'd0);
      in_sel = 1'b0;
      #1;
      chk("in_ready_ch4", 32'(in_ready), 32'd1);
      step();
      check_all("in_intr");

      // Core writes to inputs and a second offer while pending are ignored
      wr(3'd5, 15'o11111);
      step();
      wr(3'd4, 15'o22222);
      step();
      in_valid = 1'b1; in_sel = 1'b1; in_data = 15'o00555;
      step();
      check_all("in_ignored");

      // Ack on a non-input channel has no effect, then ack channel 5
      IO_read_sel = 3'd3; IO_read_ack = 1'b1;
      step();
      check_all("ack_other");
      IO_read_sel = 3'd5; IO_read_ack = 1'b1;
      step();
      check_all("ack_ch5");
      step();
      check_all("ack_intr");

      // Accept on one channel while acking the other
      in_valid = 1'b1; in_sel = 1'b1; in_data = 15'o00123;
      step();
      in_valid = 1'b1; in_sel = 1'b0; in_data = 15'o00321;
      IO_read_sel = 3'd5; IO_read_ack = 1'b1;
      step();
      check_all("cross");
      IO_read_sel = 3'd4; IO_read_ack = 1'b1;
      step();
      step();
      check_all("cross_done");

      // Asynchronous reset in the middle of a drain
      wr(3'd2, 15'o00011);
      step();
      wr(3'd3, 15'o00022);
      step();
      in_valid = 1'b1; in_sel = 1'b0; in_data = 15'o00444;
      step();
      out_ready = 1'b1;
      #5;
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_valid", 32'(out_valid), 32'd0);
      chk("async_reset_data", 32'(out_data), 32'd0);
      sb.delete();
      for (int i = 0; i < 8; i++) mch[i] = '0;
      mpend = 2'b00; movf = 1'b0; mintr = 1'b0;
      out_ready = 1'b0;
      step();
      reset_n = 1'b1;
      check_all("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/io_channel_unit.md
Name: io_channel_unit

Overview:
- Downstream consumer of the Core's IO port; owns the 8 AGC-style IO channels addressed by the Core's 3-bit IO_read_sel / IO_write_sel.
- Output channels 0-3 are latched and also queued in a FIFO that drains to a peripheral over a valid/ready link.
- Input channels 4-5 are filled by the peripheral over a second valid/ready link, with per-channel pending flags.
- Channel 6 is a read-only status word; channel 7 is scratch.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; must be 2 or 4 (count must fit 3 bits).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- IO_write_en  input  1  Core write strobe (writeback stage)
- IO_write_sel  input  3  channel to write
- IO_write_data  input  15  write data
- IO_read_sel  input  3  channel to read (decode stage)
- IO_read_data  output  15  combinational read data
- IO_read_ack  input  1  Core commits the read of IO_read_sel; clears that channel's pending flag
- out_valid  output  1  FIFO head valid
- out_ready  input  1  peripheral accepts head
- out_sel  output  3  head channel number
- out_data  output  15  head data
- in_valid  input  1  peripheral offers input word
- in_ready  output  1  unit can accept the word
- in_sel  input  1  0 selects channel 4, 1 selects channel 5
- in_data  input  15  input word
- io_intr  output  1  present only with IO_INTR_EN

Behaviour:
- Reset (async, reset_n low):
  - all channel registers 0; pending[1:0]=0; overflow=0; FIFO empty.
  - Outputs: out_valid=0, out_sel=0, out_data=0, in_ready=1, IO_read_data=0.
- Read path:
  - IO_read_data = channel[IO_read_sel], purely combinational, no write bypass.
  - A same-cycle write to that channel is seen the next cycle.
- Writes on the rising edge with IO_write_en=1, by IO_write_sel:
  - 0-3: channel register updated; {sel,data} pushed to FIFO.
  - 7: channel register updated; no push.
  - 4, 5: ignored.
  - 6: only IO_write_data[14]=1 clears overflow; other bits ignored.
- Status (channel 6), rebuilt every cycle:
  - [14] overflow; [13:11] FIFO count; [10:2] 0; [1] pending ch5; [0] pending ch4.
- FIFO:
  - Circular buffer with head/tail pointers wrapping at FIFO_DEPTH; count range 0..FIFO_DEPTH.
  - out_valid = (count != 0); out_sel/out_data driven from head storage.
  - Pop when out_valid && out_ready.
  - Push latency: a write at edge N gives out_valid=1 from edge N onward if the FIFO was empty.
  - Push while full with no pop in the same cycle: entry dropped, overflow set (sticky), channel register still updated.
  - Push while full with a pop in the same cycle: push accepted; count unchanged.
  - Push and pop on a non-full FIFO: count unchanged.
- Input link:
  - in_ready = ~pending[in_sel], combinational.
  - On in_valid && in_ready: channel[4+in_sel] <= in_data; pending[in_sel] <= 1.
- Pending clear:
  - IO_read_ack with IO_read_sel==4 or 5 clears the matching pending bit; acks on other channels have no effect.
  - Accept and ack cannot hit the same channel in one cycle, because in_ready is 0 while pending.
  - An ack on one channel and an accept on the other are independent.
- Reset asserted mid-transfer: FIFO contents discarded and out_valid drops immediately (async); a partially handshaken input word is lost.

Optional Feature:
- Macro: IO_INTR_EN.
- Defined: io_intr port exists; registered, equals |pending one cycle late; reset 0.
- Undefined: io_intr port and its logic are absent; otherwise identical.

Decomposition:
- Package io_pkg holds:
  - channel constants CH_OUT0..CH_OUT3=0..3, CH_IN0=4, CH_IN1=5, CH_STATUS=6, CH_SCRATCH=7;
  - status bit positions STAT_OVF=14, STAT_CNT_MSB=13, STAT_CNT_LSB=11;
  - typedef io_fifo_entry_t packed struct {logic [2:0] sel; logic [14:0] data;}.
- Sub-module io_out_fifo (parameter FIFO_DEPTH, entry type io_fifo_entry_t): push, push_ok, pop, head, count. It keeps the overflow and full/pop logic local to the FIFO.

Test Plan:
- Reset, then idle -> out_valid=0, in_ready=1, IO_read_data=0 for every sel; status reads 15'o00000.
- Write ch2=15'o12345 with out_ready=0 -> next cycle ch2 reads 15'o12345; out_valid=1, out_sel=2, out_data=15'o12345; status count=1. Raise out_ready one cycle -> out_valid=0.
- Five writes to ch0 (1..5), out_ready=0, FIFO_DEPTH=4 -> count=4, overflow=1 (status[14]=1), ch0 reads 5. Drain -> out_data sequence 1,2,3,4. Write ch6=15'o40000 -> status reads 0.
- FIFO full, write ch1 with out_ready=1 in the same cycle -> push accepted, count stays 4, overflow stays 0.
- in_valid=1, in_sel=1, in_data=15'o00777 -> ch5 reads 15'o00777, status[1]=1, in_ready=0 for in_sel=1. IO_read_sel=5 with IO_read_ack=1 -> status[1]=0, in_ready=1.
- Writes to ch4/ch5 while pending: values unchanged. Assert reset_n low mid-drain -> out_valid=0 immediately. With IO_INTR_EN: io_intr rises one cycle after input accept and falls one cycle after ack.
